branch_predictor: RTL and testbench

- Fetch-side branch predictor. It produces the prediction and target that branchHandler checks in EX, and it consumes EX-stage resolution to train itself.
- Direct-mapped table indexed by PC. Each entry holds a valid bit, a tag, a 2-bit saturating counter and a branch target.
- Lookup is combinational off registered state in IF. Training writes at the clock edge after EX resolution.
- Also keeps saturating branch and mispredict performance counters.

---
 rtl/branch_predictor_pkg.sv | 24 ++
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_predictor_sat_counter2.sv | 37 +++
 rtl/branch_predictor.sv | 94 +++++++++
 tb/tb_branch_predictor.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared encodings and PC slice helpers for the branch predictor
package branch_predictor_pkg;

    typedef enum logic [3:0] {
        OP_ALU_R  = 4'b0000,
        OP_ALU_I  = 4'b0001,
        OP_BRANCH = 4'b0010
    } opcode_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Word-aligned PCs: bits [1:0] never take part in index or tag.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_bits);
        return (pc >> 2) & ((64'd1 << idx_bits) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch lookup, EX training and perf counter bundle
interface branch_predictor_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] IF_PC;
    logic             pred_taken;
    logic [DBITS-1:0] pred_target;
    logic             EX_update;
    logic [DBITS-1:0] EX_PC;
    logic [DBITS-1:0] EX_PC_IMM;
    logic             EX_condFlag;
    logic             EX_correct;
    logic [DBITS-1:0] branch_count;
    logic [DBITS-1:0] mispredict_count;

    modport master (
        output IF_PC, EX_update, EX_PC, EX_PC_IMM, EX_condFlag, EX_correct,
        input  pred_taken, pred_target, branch_count, mispredict_count
    );

    modport slave (
        input  IF_PC, EX_update, EX_PC, EX_PC_IMM, EX_condFlag, EX_correct,
        output pred_taken, pred_target, branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit up/down saturating counter with load
module branch_predictor_sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    output logic [1:0] ctr_o
);
    logic [1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (load_i) begin
            ctr_d = load_val_i;
        end else if (en_i) begin
            if (up_i) begin
                ctr_d = (ctr_q == CTR_ST) ? CTR_ST : ctr_q + 2'd1;
            end else begin
                ctr_d = (ctr_q == CTR_SNT) ? CTR_SNT : ctr_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q <= CTR_WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped 2-bit branch predictor with perf counters
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = DBITS - IDX_BITS - 2
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bp
);
    localparam int ENTRIES = 1 << IDX_BITS;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [DBITS-1:0]    target_q [ENTRIES];
    logic [1:0]          ctr_w    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic [DBITS-1:0]    branch_count_q, branch_count_d;
    logic [DBITS-1:0]    mispredict_count_q, mispredict_count_d;

    assign if_idx = IDX_BITS'(pc_index(64'(bp.IF_PC), IDX_BITS));
    assign if_tag = TAG_BITS'(pc_tag(64'(bp.IF_PC), IDX_BITS));
    assign ex_idx = IDX_BITS'(pc_index(64'(bp.EX_PC), IDX_BITS));
    assign ex_tag = TAG_BITS'(pc_tag(64'(bp.EX_PC), IDX_BITS));

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign ex_hit         = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    assign bp.pred_taken  = if_hit && ctr_w[if_idx][1];
    assign bp.pred_target = bp.pred_taken ? target_q[if_idx] : bp.IF_PC + DBITS'(4);

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic sel;
        assign sel = bp.EX_update && (ex_idx == IDX_BITS'(i));
        branch_predictor_sat_counter2 u_ctr (
            .clk        (clk),
            .rst        (reset),
            .en_i       (sel && ex_hit),
            .up_i       (bp.EX_condFlag),
            .load_i     (sel && !ex_hit),
            .load_val_i (bp.EX_condFlag ? CTR_WT : CTR_WNT),
            .ctr_o      (ctr_w[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
        end else if (bp.EX_update) begin
            if (!ex_hit) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= bp.EX_PC_IMM;
            end else if (bp.EX_condFlag) begin
                target_q[ex_idx] <= bp.EX_PC_IMM;
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bp.EX_update) begin
            if (!(&branch_count_q)) begin
                branch_count_d = branch_count_q + DBITS'(1);
            end
            if (!bp.EX_correct && !(&mispredict_count_q)) begin
                mispredict_count_d = mispredict_count_q + DBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_if #(.DBITS(32)) bp_if ();
    branch_predictor_if #(.DBITS(8))  sat_if ();

    branch_predictor #(.DBITS(32), .IDX_BITS(4)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bp    (bp_if.slave)
    );

    // Narrow instance so the perf counters can be driven to saturation quickly.
    branch_predictor #(.DBITS(8), .IDX_BITS(4)) u_sat (
        .clk   (clk),
        .reset (rst),
        .bp    (sat_if.slave)
    );

    typedef struct {
        logic [31:0] if_pc;
        logic        upd;
        logic [31:0] ex_pc;
        logic [31:0] ex_imm;
        logic        cond;
        logic        corr;
        logic        exp_taken;
        logic [31:0] exp_tgt;
        logic [31:0] exp_bc;
        logic [31:0] exp_mc;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(input logic [31:0] if_pc, input logic upd, input logic [31:0] ex_pc,
                                input logic [31:0] ex_imm, input logic cond, input logic corr,
                                input logic exp_taken, input logic [31:0] exp_tgt,
                                input logic [31:0] exp_bc, input logic [31:0] exp_mc);
        vec_t v;
        v.if_pc = if_pc; v.upd = upd; v.ex_pc = ex_pc; v.ex_imm = ex_imm;
        v.cond = cond; v.corr = corr; v.exp_taken = exp_taken; v.exp_tgt = exp_tgt;
        v.exp_bc = exp_bc; v.exp_mc = exp_mc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bp_if.IF_PC       = v.if_pc;
        bp_if.EX_update   = v.upd;
        bp_if.EX_PC       = v.ex_pc;
        bp_if.EX_PC_IMM   = v.ex_imm;
        bp_if.EX_condFlag = v.cond;
        bp_if.EX_correct  = v.corr;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        drive(mk(32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0));
        sat_if.IF_PC = 8'h10; sat_if.EX_update = 1'b0; sat_if.EX_PC = 8'h10;
        sat_if.EX_PC_IMM = 8'h40; sat_if.EX_condFlag = 1'b1; sat_if.EX_correct = 1'b0;

        // if_pc upd ex_pc ex_imm cond corr | taken target bc mc (pre-update view)
        vecs.push_back(mk(32'h10, 0, 32'h00, 32'h00,  0, 1, 0, 32'h14,  0, 0));
        vecs.push_back(mk(32'h10, 1, 32'h10, 32'h40,  1, 0, 0, 32'h14,  0, 0));
        vecs.push_back(mk(32'h10, 0, 32'h00, 32'h00,  0, 1, 1, 32'h40,  1, 1));
        vecs.push_back(mk(32'h10, 1, 32'h10, 32'h40,  1, 1, 1, 32'h40,  1, 1));
        vecs.push_back(mk(32'h10, 1, 32'h10, 32'h40,  1, 1, 1, 32'h40,  2, 1));
        vecs.push_back(mk(32'h10, 1, 32'h10, 32'h40,  1, 1, 1, 32'h40,  3, 1));
        vecs.push_back(mk(32'h10, 1, 32'h10, 32'h77,  0, 0, 1, 32'h40,  4, 1));
        vecs.push_back(mk(32'h10, 0, 32'h00, 32'h00,  0, 1, 1, 32'h40,  5, 2));
        vecs.push_back(mk(32'h10, 1, 32'h10, 32'h40,  0, 0, 1, 32'h40,  5, 2));
        vecs.push_back(mk(32'h10, 0, 32'h00, 32'h00,  0, 1, 0, 32'h14,  6, 3));
        vecs.push_back(mk(32'h10, 1, 32'h10, 32'h80,  1, 1, 0, 32'h14,  6, 3));
        vecs.push_back(mk(32'h10, 0, 32'h00, 32'h00,  0, 1, 1, 32'h80,  7, 3));
        vecs.push_back(mk(32'h10, 1, 32'h50, 32'h99,  0, 1, 1, 32'h80,  7, 3));
        vecs.push_back(mk(32'h10, 0, 32'h00, 32'h00,  0, 1, 0, 32'h14,  8, 3));
        vecs.push_back(mk(32'h50, 1, 32'h50, 32'h99,  0, 1, 0, 32'h54,  8, 3));
        vecs.push_back(mk(32'h50, 1, 32'h50, 32'h120, 1, 0, 0, 32'h54,  9, 3));
        vecs.push_back(mk(32'h50, 0, 32'h00, 32'h00,  0, 1, 0, 32'h54, 10, 4));
        vecs.push_back(mk(32'h53, 1, 32'h52, 32'h124, 1, 1, 0, 32'h57, 10, 4));
        vecs.push_back(mk(32'h52, 0, 32'h00, 32'h00,  0, 1, 1, 32'h124, 11, 4));
        vecs.push_back(mk(32'hFFFFFFFC, 0, 32'h10, 32'h55, 1, 0, 0, 32'h0, 11, 4));
        vecs.push_back(mk(32'hFFFFFFFC, 0, 32'h00, 32'h00, 0, 1, 0, 32'h0, 11, 4));

        #12;
        chk("reset_pred_taken", {31'b0, bp_if.pred_taken}, 32'h0);
        chk("reset_pred_target", bp_if.pred_target, 32'h14);
        chk("reset_branch_count", bp_if.branch_count, 32'h0);
        chk("reset_mispredict_count", bp_if.mispredict_count, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d_pred_taken", i), {31'b0, bp_if.pred_taken}, {31'b0, e.exp_taken});
            chk($sformatf("v%0d_pred_target", i), bp_if.pred_target, e.exp_tgt);
            chk($sformatf("v%0d_branch_count", i), bp_if.branch_count, e.exp_bc);
            chk($sformatf("v%0d_mispredict_count", i), bp_if.mispredict_count, e.exp_mc);
        end

        // Asynchronous reset mid-cycle while an update is pending.
        @(posedge clk); #1;
        drive(mk(32'h50, 1, 32'h50, 32'h200, 0, 0, 0, 32'h0, 0, 0));
        #3;
        chk("pre_async_pred_taken", {31'b0, bp_if.pred_taken}, 32'h1);
        chk("pre_async_pred_target", bp_if.pred_target, 32'h124);
        rst = 1'b1;
        #1;
        chk("async_pred_taken", {31'b0, bp_if.pred_taken}, 32'h0);
        chk("async_pred_target", bp_if.pred_target, 32'h54);
        chk("async_branch_count", bp_if.branch_count, 32'h0);
        chk("async_mispredict_count", bp_if.mispredict_count, 32'h0);
        @(posedge clk); #1;
        bp_if.EX_update = 1'b0;
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_pred_taken", {31'b0, bp_if.pred_taken}, 32'h0);
        chk("post_reset_branch_count", bp_if.branch_count, 32'h0);

        // Saturation of both perf counters on the 8-bit instance.
        @(posedge clk); #1;
        sat_if.EX_update = 1'b1;
        repeat (254) @(posedge clk);
        #1;
        chk("sat_branch_254", {24'b0, sat_if.branch_count}, 32'hFE);
        chk("sat_mispredict_254", {24'b0, sat_if.mispredict_count}, 32'hFE);
        @(posedge clk); #1;
        chk("sat_branch_255", {24'b0, sat_if.branch_count}, 32'hFF);
        repeat (45) @(posedge clk);
        #1;
        sat_if.EX_update = 1'b0;
        chk("sat_branch_hold", {24'b0, sat_if.branch_count}, 32'hFF);
        chk("sat_mispredict_hold", {24'b0, sat_if.mispredict_count}, 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
